// File: rtl/mem_stage_if.sv
// Bundle of EX-side, data-memory and write-back signals for the EX/MEM stage.
// Valid/ready: EX holds valid_in and operands while stall_out=1; dmem_req_out is held with stable fields until dmem_ack_in=1.
interface mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              valid_in;
  logic              flush_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] store_data_in;
  logic [REG_W-1:0]  dest_reg_in;
  logic              reg_write_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              stall_out;
  logic              dmem_req_out;
  logic              dmem_we_out;
  logic [DATA_W-1:0] dmem_addr_out;
  logic [DATA_W-1:0] dmem_wdata_out;
  logic              dmem_ack_in;
  logic [DATA_W-1:0] dmem_rdata_in;
  logic              wb_valid_out;
  logic              wb_reg_write_out;
  logic [REG_W-1:0]  wb_dest_out;
  logic [DATA_W-1:0] wb_data_out;
  logic              misalign_out;
  logic              state_dbg;

  modport slave (
    input  valid_in, flush_in, alu_result_in, store_data_in, dest_reg_in,
           reg_write_in, mem_read_in, mem_write_in, dmem_ack_in, dmem_rdata_in,
    output stall_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
           wb_valid_out, wb_reg_write_out, wb_dest_out, wb_data_out,
           misalign_out, state_dbg
  );

  modport master (
    output valid_in, flush_in, alu_result_in, store_data_in, dest_reg_in,
           reg_write_in, mem_read_in, mem_write_in, dmem_ack_in, dmem_rdata_in,
    input  stall_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
           wb_valid_out, wb_reg_write_out, wb_dest_out, wb_data_out,
           misalign_out, state_dbg
  );
endinterface

// File: rtl/mem_stage.sv
// EX/MEM stage: registers ALU results, runs the word load/store handshake with
// data memory, and emits one registered write-back result per instruction.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, state_next;

  logic accept, is_store, is_load, is_mem, misaligned, ack_taken, kill;

  logic              req_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [REG_W-1:0]  dest_q;
  logic              reg_write_q, load_q, flushed_q;

  logic              wb_valid_q, wb_reg_write_q, misalign_q;
  logic [REG_W-1:0]  wb_dest_q;
  logic [DATA_W-1:0] wb_data_q;

  always_comb begin
    accept     = 1'b0;
    is_store   = 1'b0;
    is_load    = 1'b0;
    is_mem     = 1'b0;
    misaligned = 1'b0;
    ack_taken  = 1'b0;
    kill       = 1'b0;
    state_next = state;

    is_store   = bus.mem_write_in;
    is_load    = !bus.mem_write_in && bus.mem_read_in;
    is_mem     = is_store || is_load;
    misaligned = (bus.alu_result_in[1:0] != 2'b00);
    // A flush arriving in the ack cycle still squashes the write-back.
    kill       = flushed_q || bus.flush_in;

    case (state)
      IDLE: begin
        accept = bus.valid_in && !bus.flush_in;
        if (accept && is_mem && !misaligned) state_next = ACCESS;
      end
      ACCESS: begin
        ack_taken = req_q && bus.dmem_ack_in;
        if (ack_taken) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      dest_q         <= '0;
      reg_write_q    <= 1'b0;
      load_q         <= 1'b0;
      flushed_q      <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_dest_q      <= '0;
      wb_data_q      <= '0;
      misalign_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;

      if (accept) begin
        if (!is_mem) begin
          wb_valid_q     <= 1'b1;
          wb_reg_write_q <= bus.reg_write_in;
          wb_dest_q      <= bus.dest_reg_in;
          wb_data_q      <= bus.alu_result_in;
        end else if (misaligned) begin
          misalign_q     <= 1'b1;
          wb_valid_q     <= 1'b1;
          wb_reg_write_q <= 1'b0;
          wb_dest_q      <= bus.dest_reg_in;
          wb_data_q      <= bus.alu_result_in;
        end else begin
          req_q       <= 1'b1;
          we_q        <= is_store;
          addr_q      <= {bus.alu_result_in[DATA_W-1:2], 2'b00};
          wdata_q     <= bus.store_data_in;
          dest_q      <= bus.dest_reg_in;
          reg_write_q <= bus.reg_write_in;
          load_q      <= is_load;
          flushed_q   <= 1'b0;
        end
      end

      if (state == ACCESS) begin
        if (bus.flush_in) flushed_q <= 1'b1;
        if (ack_taken) begin
          req_q     <= 1'b0;
          flushed_q <= 1'b0;
          if (!kill) begin
            wb_valid_q     <= 1'b1;
            wb_reg_write_q <= load_q && reg_write_q;
            wb_dest_q      <= dest_q;
            wb_data_q      <= load_q ? bus.dmem_rdata_in : addr_q;
          end
        end
      end
    end
  end

  assign bus.stall_out        = (state == ACCESS);
  assign bus.state_dbg        = state;
  assign bus.dmem_req_out     = req_q;
  assign bus.dmem_we_out      = we_q;
  assign bus.dmem_addr_out    = addr_q;
  assign bus.dmem_wdata_out   = wdata_q;
  assign bus.wb_valid_out     = wb_valid_q;
  assign bus.wb_reg_write_out = wb_reg_write_q;
  assign bus.wb_dest_out      = wb_dest_q;
  assign bus.wb_data_out      = wb_data_q;
  assign bus.misalign_out     = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one task per scenario, each with inline checks.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in      = 1'b0;
    bus.flush_in      = 1'b0;
    bus.alu_result_in = '0;
    bus.store_data_in = '0;
    bus.dest_reg_in   = '0;
    bus.reg_write_in  = 1'b0;
    bus.mem_read_in   = 1'b0;
    bus.mem_write_in  = 1'b0;
    bus.dmem_ack_in   = 1'b0;
    bus.dmem_rdata_in = '0;
  endtask

  task automatic present(input logic [31:0] alu, input logic [31:0] sdata,
                         input logic [4:0] dest, input logic rw,
                         input logic rd, input logic wr);
    bus.valid_in      = 1'b1;
    bus.alu_result_in = alu;
    bus.store_data_in = sdata;
    bus.dest_reg_in   = dest;
    bus.reg_write_in  = rw;
    bus.mem_read_in   = rd;
    bus.mem_write_in  = wr;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h expected 0", bus.stall_out); end
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h expected 0", bus.dmem_req_out); end
    checks++; if (bus.wb_valid_out !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0h expected 0", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %0h expected 0", bus.wb_data_out); end
    checks++; if (bus.dmem_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.dmem_addr_out); end
    checks++; if (bus.misalign_out !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0h expected 0", bus.misalign_out); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_op();
    present(32'h0000_0007, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall_pre: got %0h expected 0", bus.stall_out); end
    step();
    idle_inputs();
    checks++; if (bus.wb_valid_out !== 1'b1) begin errors++; $display("FAIL alu_wb_valid: got %0h expected 1", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'h7) begin errors++; $display("FAIL alu_wb_data: got %0h expected 7", bus.wb_data_out); end
    checks++; if (bus.wb_dest_out !== 5'd5) begin errors++; $display("FAIL alu_wb_dest: got %0d expected 5", bus.wb_dest_out); end
    checks++; if (bus.wb_reg_write_out !== 1'b1) begin errors++; $display("FAIL alu_wb_rw: got %0h expected 1", bus.wb_reg_write_out); end
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0h expected 0", bus.stall_out); end
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL alu_req: got %0h expected 0", bus.dmem_req_out); end
    step();
    checks++; if (bus.wb_valid_out !== 1'b0) begin errors++; $display("FAIL alu_wb_pulse: got %0h expected 0", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'h7) begin errors++; $display("FAIL alu_wb_hold: got %0h expected 7", bus.wb_data_out); end
  endtask

  task automatic test_flush_wins();
    present(32'h0000_0055, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
    bus.flush_in = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.wb_valid_out !== 1'b0) begin errors++; $display("FAIL flushwin_wb_valid: got %0h expected 0", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'h7) begin errors++; $display("FAIL flushwin_wb_data: got %0h expected 7", bus.wb_data_out); end
  endtask

  task automatic test_load();
    present(32'h0000_0100, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.dmem_req_out !== 1'b1) begin errors++; $display("FAIL load_req c%0d: got %0h expected 1", i, bus.dmem_req_out); end
      checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL load_stall c%0d: got %0h expected 1", i, bus.stall_out); end
      checks++; if (bus.state_dbg !== 1'b1) begin errors++; $display("FAIL load_state c%0d: got %0h expected 1", i, bus.state_dbg); end
      checks++; if (bus.wb_valid_out !== 1'b0) begin errors++; $display("FAIL load_wb_early c%0d: got %0h expected 0", i, bus.wb_valid_out); end
      checks++; if (bus.dmem_we_out !== 1'b0) begin errors++; $display("FAIL load_we c%0d: got %0h expected 0", i, bus.dmem_we_out); end
      checks++; if (bus.dmem_addr_out !== 32'h100) begin errors++; $display("FAIL load_addr c%0d: got %0h expected 100", i, bus.dmem_addr_out); end
      if (i == 3) begin
        bus.dmem_ack_in   = 1'b1;
        bus.dmem_rdata_in = 32'hDEAD_BEEF;
      end
      step();
    end
    idle_inputs();
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %0h expected 0", bus.dmem_req_out); end
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL load_stall_drop: got %0h expected 0", bus.stall_out); end
    checks++; if (bus.wb_valid_out !== 1'b1) begin errors++; $display("FAIL load_wb_valid: got %0h expected 1", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_wb_data: got %0h expected deadbeef", bus.wb_data_out); end
    checks++; if (bus.wb_reg_write_out !== 1'b1) begin errors++; $display("FAIL load_wb_rw: got %0h expected 1", bus.wb_reg_write_out); end
    checks++; if (bus.wb_dest_out !== 5'd12) begin errors++; $display("FAIL load_wb_dest: got %0d expected 12", bus.wb_dest_out); end
    step();
    checks++; if (bus.wb_valid_out !== 1'b0) begin errors++; $display("FAIL load_wb_pulse: got %0h expected 0", bus.wb_valid_out); end
  endtask

  task automatic test_store();
    // mem_read also set: store takes priority
    present(32'h0000_0104, 32'hCAFE_F00D, 5'd3, 1'b1, 1'b1, 1'b1);
    step();
    idle_inputs();
    bus.dmem_ack_in = 1'b1;
    checks++; if (bus.dmem_req_out !== 1'b1) begin errors++; $display("FAIL store_req: got %0h expected 1", bus.dmem_req_out); end
    checks++; if (bus.dmem_we_out !== 1'b1) begin errors++; $display("FAIL store_we: got %0h expected 1", bus.dmem_we_out); end
    checks++; if (bus.dmem_wdata_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_wdata: got %0h expected cafef00d", bus.dmem_wdata_out); end
    checks++; if (bus.dmem_addr_out !== 32'h104) begin errors++; $display("FAIL store_addr: got %0h expected 104", bus.dmem_addr_out); end
    step();
    idle_inputs();
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL store_req_drop: got %0h expected 0", bus.dmem_req_out); end
    checks++; if (bus.wb_valid_out !== 1'b1) begin errors++; $display("FAIL store_wb_valid: got %0h expected 1", bus.wb_valid_out); end
    checks++; if (bus.wb_reg_write_out !== 1'b0) begin errors++; $display("FAIL store_wb_rw: got %0h expected 0", bus.wb_reg_write_out); end
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL store_stall: got %0h expected 0", bus.stall_out); end
  endtask

  task automatic test_misaligned_back_to_back();
    present(32'h0000_0102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    step();
    present(32'h0000_0011, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL mis_req: got %0h expected 0", bus.dmem_req_out); end
    checks++; if (bus.misalign_out !== 1'b1) begin errors++; $display("FAIL mis_flag: got %0h expected 1", bus.misalign_out); end
    checks++; if (bus.wb_valid_out !== 1'b1) begin errors++; $display("FAIL mis_wb_valid: got %0h expected 1", bus.wb_valid_out); end
    checks++; if (bus.wb_reg_write_out !== 1'b0) begin errors++; $display("FAIL mis_wb_rw: got %0h expected 0", bus.wb_reg_write_out); end
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL mis_stall: got %0h expected 0", bus.stall_out); end
    step();
    idle_inputs();
    checks++; if (bus.wb_valid_out !== 1'b1) begin errors++; $display("FAIL b2b_wb_valid: got %0h expected 1", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'h11) begin errors++; $display("FAIL b2b_wb_data: got %0h expected 11", bus.wb_data_out); end
    checks++; if (bus.wb_dest_out !== 5'd9) begin errors++; $display("FAIL b2b_wb_dest: got %0d expected 9", bus.wb_dest_out); end
    checks++; if (bus.misalign_out !== 1'b0) begin errors++; $display("FAIL b2b_misalign: got %0h expected 0", bus.misalign_out); end
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL b2b_req: got %0h expected 0", bus.dmem_req_out); end
    step();
  endtask

  task automatic test_flush_in_access();
    present(32'h0000_0200, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    step();
    idle_inputs();
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    checks++; if (bus.dmem_req_out !== 1'b1) begin errors++; $display("FAIL flush_req_held: got %0h expected 1", bus.dmem_req_out); end
    checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL flush_stall_held: got %0h expected 1", bus.stall_out); end
    bus.dmem_ack_in   = 1'b1;
    bus.dmem_rdata_in = 32'h1234_5678;
    step();
    idle_inputs();
    checks++; if (bus.wb_valid_out !== 1'b0) begin errors++; $display("FAIL flush_wb_valid: got %0h expected 0", bus.wb_valid_out); end
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL flush_req_drop: got %0h expected 0", bus.dmem_req_out); end
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall_drop: got %0h expected 0", bus.stall_out); end
    present(32'h0000_0021, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    idle_inputs();
    checks++; if (bus.wb_valid_out !== 1'b1) begin errors++; $display("FAIL postflush_wb_valid: got %0h expected 1", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'h21) begin errors++; $display("FAIL postflush_wb_data: got %0h expected 21", bus.wb_data_out); end
    checks++; if (bus.wb_reg_write_out !== 1'b1) begin errors++; $display("FAIL postflush_wb_rw: got %0h expected 1", bus.wb_reg_write_out); end
    step();
  endtask

  task automatic test_reset_in_access();
    present(32'h0000_0300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
    step();
    idle_inputs();
    checks++; if (bus.dmem_req_out !== 1'b1) begin errors++; $display("FAIL rstacc_req_pre: got %0h expected 1", bus.dmem_req_out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.dmem_req_out !== 1'b0) begin errors++; $display("FAIL rstacc_req: got %0h expected 0", bus.dmem_req_out); end
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL rstacc_stall: got %0h expected 0", bus.stall_out); end
    checks++; if (bus.wb_data_out !== 32'h0) begin errors++; $display("FAIL rstacc_wb_data: got %0h expected 0", bus.wb_data_out); end
    checks++; if (bus.dmem_addr_out !== 32'h0) begin errors++; $display("FAIL rstacc_addr: got %0h expected 0", bus.dmem_addr_out); end
    checks++; if (bus.wb_dest_out !== 5'd0) begin errors++; $display("FAIL rstacc_wb_dest: got %0d expected 0", bus.wb_dest_out); end
    bus.dmem_ack_in   = 1'b1;
    bus.dmem_rdata_in = 32'hFFFF_0000;
    step();
    idle_inputs();
    checks++; if (bus.wb_valid_out !== 1'b0) begin errors++; $display("FAIL lateack_wb_valid: got %0h expected 0", bus.wb_valid_out); end
    checks++; if (bus.wb_data_out !== 32'h0) begin errors++; $display("FAIL lateack_wb_data: got %0h expected 0", bus.wb_data_out); end
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL lateack_stall: got %0h expected 0", bus.stall_out); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_op();
    test_flush_wins();
    test_load();
    test_store();
    test_misaligned_back_to_back();
    test_flush_in_access();
    test_reset_in_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
